branch_redirect_ctrl: RTL and testbench

Program-counter redirect controller for the CMPE200 pipeline. It consumes the taken/not-taken bit from the branch condition evaluator, computes branch and jump targets, and owns the fetch PC. It drives a one-cycle pipeline flush and holds a pending redirect until instruction memory accepts the in-flight fetch. It sits between the decode/execute-stage branch logic and the instruction-fetch stage.

---
 rtl/branch_redirect_ctrl_if.sv | 40 ++++
 rtl/branch_redirect_ctrl.sv | 111 +++++++++++
 tb/tb_branch_redirect_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl_if
// Description : Branch/jump request, fetch handshake and redirect status
//               bundle between the execute-stage branch logic and fetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic             br_taken;
    logic [31:0]      br_pc;
    logic [15:0]      br_offset;
    logic             jmp_valid;
    logic [31:0]      jmp_pc;
    logic [25:0]      jmp_index;
    logic             stall_in;
    logic             imem_ack;
    logic [31:0]      pc;
    logic             fetch_req;
    logic             flush;
    logic             redirect_pend;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output br_valid, br_taken, br_pc, br_offset,
        output jmp_valid, jmp_pc, jmp_index,
        output stall_in, imem_ack,
        input  pc, fetch_req, flush, redirect_pend, redirect_cnt
    );

    modport slave (
        input  br_valid, br_taken, br_pc, br_offset,
        input  jmp_valid, jmp_pc, jmp_index,
        input  stall_in, imem_ack,
        output pc, fetch_req, flush, redirect_pend, redirect_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Owns the fetch PC; turns taken branches and jumps into a
//               one-cycle flush plus a redirect held until imem accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  wire                   clk,
    input  wire                   rst,
    branch_redirect_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_tgt;
    logic             r_flush;
    logic [CNT_W-1:0] r_cnt;

    logic             w_redirect;
    logic [31:0]      w_br_tgt;
    logic [31:0]      w_jmp_pc4;
    logic [31:0]      w_jmp_tgt;
    logic [31:0]      w_target;
    logic             w_capture;
    logic             w_advance;
    logic             w_load;
    logic             w_unused_jmp;

    assign w_br_tgt  = bus.br_pc + 32'd4 + {{14{bus.br_offset[15]}}, bus.br_offset, 2'b00};
    assign w_jmp_pc4 = bus.jmp_pc + 32'd4;
    assign w_jmp_tgt = {w_jmp_pc4[31:28], bus.jmp_index, 2'b00};
    // Low bits of the jump's pc+4 only matter through the carry into [31:28].
    assign w_unused_jmp = ^w_jmp_pc4[27:0];

    // A taken branch is older than a same-cycle jump, so it wins.
    assign w_redirect = (bus.br_valid && bus.br_taken) || bus.jmp_valid;
    assign w_target   = (bus.br_valid && bus.br_taken) ? w_br_tgt : w_jmp_tgt;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            RUN: begin
                if (w_redirect) begin
                    w_capture    = 1'b1;
                    w_state_next = REDIR;
                end else if (bus.imem_ack && !bus.stall_in) begin
                    w_advance = 1'b1;
                end
            end
            REDIR: begin
                if (bus.imem_ack) begin
                    w_load       = 1'b1;
                    w_state_next = RUN;
                end
            end
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_tgt   <= 32'd0;
            r_flush <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_flush <= w_capture;
            if (w_capture) begin
                r_tgt <= w_target;
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_advance) begin
                r_pc <= r_pc + 32'd4;
            end else if (w_load) begin
                r_pc <= r_tgt;
            end
        end
    end

    assign bus.pc            = r_pc;
    assign bus.flush         = r_flush;
    assign bus.redirect_pend = (r_state == REDIR);
    assign bus.redirect_cnt  = r_cnt;
    // During a redirect the wrong-path fetch must complete even under stall.
    assign bus.fetch_req     = (r_state == REDIR) || !bus.stall_in;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_redirect_ctrl
// Description : Directed plus randomized bench against a queue-based
//               behavioural model of the fetch PC redirect rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_taken, jmp_valid, stall_in, imem_ack;
    logic [31:0] br_pc, jmp_pc;
    logic [15:0] br_offset;
    logic [25:0] jmp_index;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: a non-empty target queue means a redirect is pending.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_flush;
    int          m_cnt16;
    int          m_cnt2;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.CNT_W(16)) bus16 ();
    branch_redirect_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus16.br_valid  = br_valid;   assign bus2.br_valid  = br_valid;
    assign bus16.br_taken  = br_taken;   assign bus2.br_taken  = br_taken;
    assign bus16.br_pc     = br_pc;      assign bus2.br_pc     = br_pc;
    assign bus16.br_offset = br_offset;  assign bus2.br_offset = br_offset;
    assign bus16.jmp_valid = jmp_valid;  assign bus2.jmp_valid = jmp_valid;
    assign bus16.jmp_pc    = jmp_pc;     assign bus2.jmp_pc    = jmp_pc;
    assign bus16.jmp_index = jmp_index;  assign bus2.jmp_index = jmp_index;
    assign bus16.stall_in  = stall_in;   assign bus2.stall_in  = stall_in;
    assign bus16.imem_ack  = imem_ack;   assign bus2.imem_ack  = imem_ack;

    branch_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    branch_redirect_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] branch_target(input logic [31:0] bpc, input logic [15:0] off);
        int signed soff;
        soff = int'($signed(off));
        return bpc + 32'd4 + 32'(soff * 4);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] jpc, input logic [25:0] idx);
        logic [31:0] nxt;
        nxt = jpc + 32'd4;
        return (nxt & 32'hF000_0000) | (32'(idx) * 32'd4);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_pc    = 32'h0;
            m_q.delete();
            m_flush = 1'b0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else begin
            m_flush = 1'b0;
            if (m_q.size() == 0) begin
                if ((br_valid && br_taken) || jmp_valid) begin
                    m_q.push_back((br_valid && br_taken) ? branch_target(br_pc, br_offset)
                                                         : jump_target(jmp_pc, jmp_index));
                    m_flush = 1'b1;
                    m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
                    m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                end else if (imem_ack && !stall_in) begin
                    m_pc = m_pc + 32'd4;
                end
            end else if (imem_ack) begin
                m_pc = m_q.pop_front();
            end
        end
    endtask

    task automatic check_all();
        logic pend;
        pend = (m_q.size() != 0);
        chk("pc",        {32'h0, bus16.pc},               {32'h0, m_pc});
        chk("flush",     {63'h0, bus16.flush},            {63'h0, m_flush});
        chk("pend",      {63'h0, bus16.redirect_pend},    {63'h0, pend});
        chk("fetch_req", {63'h0, bus16.fetch_req},        {63'h0, pend || !stall_in});
        chk("cnt16",     {48'h0, bus16.redirect_cnt},     64'(m_cnt16));
        chk("cnt2",      {62'h0, bus2.redirect_cnt},      64'(m_cnt2));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        rst       = 1'b0;
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        jmp_valid = 1'b0;
        stall_in  = 1'b0;
        imem_ack  = 1'b1;
    endtask

    initial begin
        quiet();
        br_pc = 32'h0; br_offset = 16'h0; jmp_pc = 32'h0; jmp_index = 26'h0;
        m_pc = 32'h0; m_flush = 1'b0; m_cnt16 = 0; m_cnt2 = 0;

        // Reset and sequential fetch
        rst = 1'b1;
        tick(); tick();
        chk("rst_pc", {32'h0, bus16.pc}, 64'h0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", {32'h0, bus16.pc}, 64'(4 * i));
        end

        // Forward taken branch, immediate ack
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h40; br_offset = 16'd3;
        tick();
        chk("fwd_flush", {63'h0, bus16.flush}, 64'h1);
        quiet();
        tick();
        chk("fwd_pc",  {32'h0, bus16.pc}, 64'h50);
        chk("fwd_cnt", {48'h0, bus16.redirect_cnt}, 64'h1);

        // Backward branch with ack held off for three cycles
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h100; br_offset = 16'hFFFC;
        tick();
        quiet();
        imem_ack = 1'b0;
        tick(); tick(); tick();
        chk("neg_hold", {32'h0, bus16.pc}, 64'h50);
        imem_ack = 1'b1;
        tick();
        chk("neg_pc", {32'h0, bus16.pc}, 64'hF4);

        // Branch and jump together: branch wins
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h20; br_offset = 16'd1;
        jmp_valid = 1'b1; jmp_pc = 32'h24; jmp_index = 26'h100;
        tick();
        quiet();
        tick();
        chk("both_pc", {32'h0, bus16.pc}, 64'h28);

        // Not-taken branch keeps sequential advance
        br_valid = 1'b1; br_taken = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("nt_pc", {32'h0, bus16.pc}, 64'(32'h28 + 4 * i));
        end
        quiet();

        // Jump under stall
        stall_in = 1'b1; jmp_valid = 1'b1; jmp_pc = 32'hF000_0000; jmp_index = 26'h3;
        tick();
        jmp_valid = 1'b0;
        chk("stall_freq", {63'h0, bus16.fetch_req}, 64'h1);
        tick();
        chk("jmp_pc", {32'h0, bus16.pc}, 64'hF000_000C);
        quiet();

        // Wrap from the top of the address space
        jmp_valid = 1'b1; jmp_pc = 32'hF000_0000; jmp_index = 26'h3FF_FFFF;
        tick();
        quiet();
        tick();
        chk("top_pc", {32'h0, bus16.pc}, 64'hFFFF_FFFC);
        tick();
        chk("wrap_pc", {32'h0, bus16.pc}, 64'h0);

        // Reset while a redirect is pending
        br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h200; br_offset = 16'd8;
        tick();
        quiet();
        imem_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_pc",    {32'h0, bus16.pc}, 64'h0);
        chk("rstmid_flush", {63'h0, bus16.flush}, 64'h0);
        chk("rstmid_pend",  {63'h0, bus16.redirect_pend}, 64'h0);
        quiet();

        // Five redirects saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            jmp_valid = 1'b1; jmp_pc = 32'(i * 64); jmp_index = 26'(i + 16);
            tick();
            jmp_valid = 1'b0;
            tick();
        end
        chk("sat_cnt2",  {62'h0, bus2.redirect_cnt}, 64'h3);
        chk("sat_cnt16", {48'h0, bus16.redirect_cnt}, 64'h5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            br_valid  = ($urandom_range(0, 3) == 0);
            br_taken  = $urandom_range(0, 1) == 1;
            br_pc     = $urandom & 32'hFFFF_FFFC;
            br_offset = 16'($urandom);
            jmp_valid = ($urandom_range(0, 7) == 0);
            jmp_pc    = $urandom & 32'hFFFF_FFFC;
            jmp_index = 26'($urandom);
            stall_in  = ($urandom_range(0, 3) == 0);
            imem_ack  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
